// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, controller state enum and RCON lookup.
// Used by the key-expansion engine and the encryption/decryption round controllers.
package aes_pkg;
  localparam int NR = 10;
  // Width of both the AES-128 key and the data block.
  localparam int KEY_W = 128;
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'(NR)) ? RCON_TBL[8*(NR-int'(r)) +: 8] : 8'h00;
  endfunction
endpackage

// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if: request/read bus of the key-expansion engine.
// start/key launch an expansion; busy/key_valid/done report progress;
// rk_idx selects a round key returned on rk_out one cycle later.
interface aes_key_expand_if;
  import aes_pkg::*;
  logic             start;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             key_valid;
  logic             done;
  logic [3:0]       rk_idx;
  logic [KEY_W-1:0] rk_out;
  modport master (output start, key, rk_idx, input busy, key_valid, done, rk_out);
  modport slave (input start, key, rk_idx, output busy, key_valid, done, rk_out);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box.
// Ports: a = input byte, y = substituted byte.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = SBOX[8*(255-int'(a)) +: 8];
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key expansion into an 11-entry round-key store.
// Ports: clk, resetn (async active-low), bus (slave side of aes_key_expand_if).
module aes_key_expand
  import aes_pkg::*;
(
  input logic             clk,
  input logic             resetn,
  aes_key_expand_if.slave bus
);
  state_t state, state_n;
  logic [3:0] round;
  logic [KEY_W-1:0] rk [0:NR];
  logic [KEY_W-1:0] cur, nxt;
  logic [31:0] rot, sub, temp, w0, w1, w2, w3;
  logic accept, last;
  assign accept = bus.start && state != EXPAND;
  assign last = state == EXPAND && round == 4'(NR);
  // cur mirrors the most recently written round key, so the schedule never reads the store.
  assign rot = {cur[23:0], cur[31:24]};
  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
  end
  assign temp = sub ^ {rcon(round), 24'h0};
  assign w0 = cur[127:96] ^ temp;
  assign w1 = cur[95:64] ^ w0;
  assign w2 = cur[63:32] ^ w1;
  assign w3 = cur[31:0] ^ w2;
  assign nxt = {w0, w1, w2, w3};
  assign bus.busy = state == EXPAND;
  assign bus.key_valid = state == READY;
  always_comb state_n = accept ? EXPAND : last ? READY : state;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      round <= '0;
      cur <= '0;
      bus.done <= 1'b0;
      bus.rk_out <= '0;
      for (int j = 0; j <= NR; j++) rk[j] <= '0;
    end else begin
      bus.done <= last;
      bus.rk_out <= (bus.rk_idx <= 4'(NR)) ? rk[bus.rk_idx] : '0;
      if (accept) begin
        rk[0] <= bus.key;
        cur <= bus.key;
        round <= 4'd1;
      end else if (state == EXPAND) begin
        rk[round] <= nxt;
        cur <= nxt;
        round <= last ? 4'd0 : round + 4'd1;
      end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: scoreboard bench for aes_key_expand against a FIPS-197 word-schedule model.
module tb_aes_key_expand;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  typedef struct {logic [127:0] v; int idx;} rd_t;
  logic clk = 0;
  logic resetn = 0;
  always #5 clk = ~clk;
  aes_key_expand_if bus();
  aes_key_expand dut (.clk(clk), .resetn(resetn), .bus(bus));
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rd_req = 0;
  logic rd_seen = 0;
  rd_t rd_q[$];
  int done_q[$];
  rd_t mon_r;
  logic [7:0] sb [0:255];
  logic [127:0] mrk [0:10];
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction
  // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv = 0;
      logic [7:0] s, t;
      for (int c = 1; c < 256; c++) if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      s = 8'h63 ^ inv;
      t = inv;
      repeat (4) begin
        t = {t[6:0], t[7]};
        s ^= t;
      end
      sb[v] = s;
    end
  endtask
  // Word-oriented FIPS-197 schedule: w[i] = w[i-4] ^ f(w[i-1]).
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge resetn)
    if (!resetn) rd_seen <= 1'b0;
    else rd_seen <= rd_req;
  always @(negedge clk)
    if (resetn) begin
      if (rd_seen) begin
        if (rd_q.size() == 0) chk("rd_q_depth", 128'(rd_q.size()), 128'd1);
        else begin
          mon_r = rd_q.pop_front();
          chk($sformatf("rk_out[%0d]", mon_r.idx), bus.rk_out, mon_r.v);
        end
      end
      if (bus.done) begin
        if (done_q.size() == 0) chk("done_unexpected", 128'(done_q.size()), 128'd1);
        else chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
      end
    end
  task automatic accept(input logic [127:0] k);
    bus.start = 1'b1;
    bus.key = k;
    done_q.push_back(cyc + 11);
    expand(k);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_accept", 128'(bus.busy), 128'd1);
    chk("kv_after_accept", 128'(bus.key_valid), 128'd0);
  endtask
  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 128'(bus.done), 128'd1);
    chk("kv_at_done", 128'(bus.key_valid), 128'd1);
    chk("busy_at_done", 128'(bus.busy), 128'd0);
  endtask
  task automatic rd(input int idx, input logic [127:0] e);
    bus.rk_idx = 4'(idx);
    rd_req = 1'b1;
    rd_q.push_back('{e, idx});
    @(negedge clk);
  endtask
  task automatic rd_end();
    rd_req = 1'b0;
    @(negedge clk);
  endtask
  task automatic sweep();
    for (int i = 0; i <= 10; i++) rd(i, mrk[i]);
    rd(11, '0);
    rd(15, '0);
    rd(int'($urandom_range(11, 15)), '0);
    rd_end();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [127:0] k;
    bus.start = 1'b0;
    bus.key = '0;
    bus.rk_idx = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_kv", 128'(bus.key_valid), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_rk_out", bus.rk_out, '0);
    resetn = 1'b1;
    @(negedge clk);
    accept(FIPS_KEY);
    wait_done();
    rd(1, FIPS_RK1);
    rd(10, FIPS_RK10);
    sweep();
    bus.start = 1'b1;
    bus.key = FIPS_KEY;
    done_q.push_back(cyc + 11);
    k = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      bus.start = (i == 3 || i == 9 || i == 10);
      bus.key = k;
      chk($sformatf("busy_ignore_%0d", i), 128'(bus.busy), 128'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_after_ignore", 128'(bus.done), 128'd1);
    chk("kv_after_ignore", 128'(bus.key_valid), 128'd1);
    rd(10, FIPS_RK10);
    rd(1, FIPS_RK1);
    rd_end();
    accept('0);
    wait_done();
    rd(10, ZERO_RK10);
    rd(1, ZERO_RK1);
    rd(0, '0);
    rd_end();
    accept(FIPS_KEY);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_kv", 128'(bus.key_valid), 128'd0);
    chk("midrst_rk_out", bus.rk_out, '0);
    done_q.delete();
    rd_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("kv_after_rst", 128'(bus.key_valid), 128'd0);
    accept(FIPS_KEY);
    wait_done();
    rd(10, FIPS_RK10);
    rd_end();
    repeat (3) begin
      accept({$urandom, $urandom, $urandom, $urandom});
      wait_done();
      sweep();
    end
    repeat (2) @(negedge clk);
    chk("done_pending", 128'(done_q.size()), 128'd0);
    chk("rd_pending", 128'(rd_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
